mem_access_stage: RTL

Parametrised memory-access pipeline stage for the SIMPLE-style core. It replaces the purely combinational memory stage with a request/acknowledge handshake to a wait-state main memory, a bounded-wait timeout, and a registered writeback result. It sits between the execute stage and the register-writeback stage, and it stalls upstream through `main_mem_waiting` while an access is outstanding.

---
 rtl/mem_access_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage with req/ack handshake, bounded wait and registered writeback
module mem_access_stage #(
  parameter int WIDTH    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] ALUres_mem,
  input  logic [WIDTH-1:0] rd1_mem,
  input  logic [WIDTH-1:0] pcinc_mem,
  input  logic [WIDTH-1:0] extended_d_mem,
  input  logic [2:0]       regwrite_dat_controll,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdat,
  input  logic [WIDTH-1:0] mem_rdat,
  input  logic             mem_ack,
  output logic             main_mem_waiting,
  output logic [WIDTH-1:0] regwrite_dat_mem,
  output logic             wb_valid,
  output logic             bus_err
);

  // A zero MAX_WAIT still needs a one-bit counter so the design elaborates.
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    wait_cnt;
  logic [WIDTH-1:0] hold_dat;   // selected non-load source, zero for selects 4..7
  logic             hold_load;  // held select was 4 (load data)
  logic             hold_read;  // access in flight is a read
  logic [WIDTH-1:0] sel_dat;
  logic             is_mem;
  logic             timeout;

  // Writeback source mux for everything except load data.
  always_comb begin
    sel_dat = '0;
    case (regwrite_dat_controll)
      3'd0:    sel_dat = ALUres_mem;
      3'd1:    sel_dat = rd1_mem;
      3'd2:    sel_dat = pcinc_mem;
      3'd3:    sel_dat = extended_d_mem;
      default: sel_dat = '0;
    endcase
  end

  assign is_mem           = mem_read | mem_write;
  assign timeout          = (MAX_WAIT != 0) && (wait_cnt == CNT_LAST);
  assign main_mem_waiting = (state == ACCESS);

  // Stage FSM: accept in IDLE, wait for ack or timeout in ACCESS; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      hold_dat         <= '0;
      hold_load        <= 1'b0;
      hold_read        <= 1'b0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdat         <= '0;
      regwrite_dat_mem <= '0;
      wb_valid         <= 1'b0;
      bus_err          <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (is_mem) begin
              // Write wins when both read and write are flagged.
              mem_req   <= 1'b1;
              mem_we    <= mem_write;
              mem_addr  <= ALUres_mem;
              mem_wdat  <= rd1_mem;
              hold_dat  <= sel_dat;
              hold_load <= (regwrite_dat_controll == 3'd4);
              hold_read <= ~mem_write;
              wait_cnt  <= '0;
              state     <= ACCESS;
            end else begin
              regwrite_dat_mem <= sel_dat;
              wb_valid         <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            // Ack has priority over a coinciding timeout.
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            state    <= IDLE;
            if (hold_load) begin
              regwrite_dat_mem <= hold_read ? mem_rdat : '0;
            end else begin
              regwrite_dat_mem <= hold_dat;
            end
          end else if (timeout) begin
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            wb_valid         <= 1'b1;
            bus_err          <= 1'b1;
            regwrite_dat_mem <= '0;
            state            <= IDLE;
          end else if (wait_cnt != CNT_SAT) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
